trapez_shaper_multi: RTL and testbench
======================================

Name: trapez_shaper_multi

Overview:
- Multi-channel trapezoidal pulse shaper with run-time programmable rise time k, flat-top gap l, pole-zero constant m and output normalisation shift.
- Per channel, per valid sample: d = v(n) − v(n−k) − v(n−l) + v(n−k−l); p += d; r = p + m·d; s += r; out = sat(s >>> norm).
- Sits between the ADC capture front-end and the peak/integral measurement logic.
- All channels share one configuration and one valid strobe.

Parameters:
- CHANNEL_SIZE, 2, number of parallel channels.
- SIZE_DATA, 16, signed input sample width.
- MAX_DELAY, 300, delay-line depth; k+l must not exceed it.
- SIZE_DELAY, 9, width of cfg_k/cfg_l; equals $clog2(MAX_DELAY+1).
- SIZE_M, 8, unsigned width of cfg_m.
- SIZE_ADD_CAPACITY, 9, extra output bits.
- SIZE_OUT, SIZE_DATA+SIZE_ADD_CAPACITY, signed output width.
- SIZE_ACC, SIZE_DATA+2*SIZE_DELAY+SIZE_M+2, internal signed width of d, p, r and s.
- DEFAULT_K, 25, reset value of k.
- DEFAULT_L, 20, reset value of l.
- DEFAULT_M, 0, reset value of m.
- DEFAULT_NORM, 10, reset value of norm.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- cfg_load  in  1  single-cycle configuration strobe.
- cfg_k  in  SIZE_DELAY  requested k.
- cfg_l  in  SIZE_DELAY  requested l.
- cfg_m  in  SIZE_M  requested m.
- cfg_norm  in  5  requested right shift.
- cfg_err  out  1  one-cycle pulse: last cfg_load was rejected.
- in_valid  in  1  samples on in_data are valid this cycle.
- in_data  in  CHANNEL_SIZE*SIZE_DATA  signed samples; channel 0 occupies the LSBs.
- out_valid  out  1  out_data is valid.
- out_data  out  CHANNEL_SIZE*SIZE_OUT  signed shaped outputs; channel 0 occupies the LSBs.
- out_sat  out  CHANNEL_SIZE  per-channel flag: the output in this beat was clipped.

Behaviour:
- Reset (asynchronous):
  - out_valid, out_data, out_sat and cfg_err = 0.
  - Delay lines, accumulators and pipeline valid bits cleared.
  - Active config = DEFAULT_*.
- Delay line:
  - Per-channel shift register, MAX_DELAY deep; shifts only on in_valid.
  - Taps at k, l and k+l are selected from the active config.
  - Unfilled history reads as 0.
- Pipeline, 4 stages, each advancing only with its own valid bit:
  - S1: register d.
  - S2: p += d; carry d forward.
  - S3: r = p + m·d (m unsigned, zero-extended).
  - S4: s += r, then normalise and saturate.
- Latency: a sample with in_valid at edge N produces out_valid = 1 after edge N+4.
  - One output beat per input beat.
  - Gaps in in_valid are allowed; output values do not depend on the gap pattern.
- Arithmetic:
  - d, p, r and s are SIZE_ACC wide, two's complement, and wrap modularly with no internal saturation.
  - Output = s arithmetic-shifted right by norm (truncation toward −inf), clipped to [−2^(SIZE_OUT−1), 2^(SIZE_OUT−1)−1].
  - out_sat[c] = 1 in any beat where clipping occurred.
- k and l are interchangeable. Rise = min(k,l) samples, flat top = |l−k| samples, height = min(k,l)·A for a step of amplitude A with m = 0.
- Configuration:
  - cfg_load is accepted when k ≥ 1, l ≥ 1 and k+l ≤ MAX_DELAY.
  - On accept, the active config updates at that edge, and delay lines, accumulators and pipeline valid bits clear at that edge.
  - A sample presented with in_valid in the same cycle as an accepted cfg_load is dropped.
  - On reject, the old config and all state are kept and cfg_err = 1 on the next cycle only. An in_valid sample in that cycle is processed normally.
- No out_valid pulses appear for samples that were in flight at an accepted reconfiguration.

Test Plan:
- Step response: k=4, l=6, m=0, norm=0; ch0 input 0 then constant 100, in_valid continuous. Required: out_data ch0 = 100,200,300,400,400,400,300,200,100,0 and then 0. First nonzero output 4 cycles after the step sample; ch1 held at 0 gives 0 throughout.
- Gapped valid: the step test repeated with in_valid every other cycle. Required: identical value sequence; each out_valid exactly 4 cycles after its input beat.
- Saturation: SIZE_ADD_CAPACITY=1 (SIZE_OUT=17), k=l=4, m=0, norm=0, step A=32767. Required outputs: 32767, 65534, 65535, 65535, 65535, 65534, 32767, 0, with out_sat=1 on the three 65535 beats only.
- Normalisation and negative input: k=4, l=6, norm=2, step A=−100. Required outputs: −25, −50, −75, −100, −100, −100, −75, −50, −25, 0.
- Reject config: cfg_k=200, cfg_l=150. Required: cfg_err=1 for exactly one cycle, then the step test still matches k=4, l=6.
- Reconfigure mid-pulse: accepted cfg_load (k=4, l=6) at the third step sample, input held at 100. Required: no out_valid for dropped or in-flight samples; the output restarts at 100,200,300,… as a fresh step. Async reset asserted mid-pulse clears all outputs immediately.

Source files
------------

// File: rtl/trapez_shaper_multi.sv
// Multi-channel trapezoidal pulse shaper.
// Per channel: a sample delay line feeds a two-stage integrator chain with
// pole-zero correction, followed by an arithmetic right shift and a clip to
// the output width. All channels share one configuration and one valid strobe.
module trapez_shaper_multi #(
  parameter int CHANNEL_SIZE      = 2,
  parameter int SIZE_DATA         = 16,
  parameter int MAX_DELAY         = 300,
  parameter int SIZE_DELAY        = 9,
  parameter int SIZE_M            = 8,
  parameter int SIZE_ADD_CAPACITY = 9,
  parameter int SIZE_OUT          = SIZE_DATA + SIZE_ADD_CAPACITY,
  parameter int SIZE_ACC          = SIZE_DATA + 2*SIZE_DELAY + SIZE_M + 2,
  parameter int DEFAULT_K         = 25,
  parameter int DEFAULT_L         = 20,
  parameter int DEFAULT_M         = 0,
  parameter int DEFAULT_NORM      = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_load,
  input  logic [SIZE_DELAY-1:0]            cfg_k,
  input  logic [SIZE_DELAY-1:0]            cfg_l,
  input  logic [SIZE_M-1:0]                cfg_m,
  input  logic [4:0]                       cfg_norm,
  output logic                             cfg_err,
  input  logic                             in_valid,
  input  logic [CHANNEL_SIZE*SIZE_DATA-1:0] in_data,
  output logic                             out_valid,
  output logic [CHANNEL_SIZE*SIZE_OUT-1:0] out_data,
  output logic [CHANNEL_SIZE-1:0]          out_sat
);

  // Sign-extend a raw sample to the accumulator width.
  function automatic logic signed [SIZE_ACC-1:0] sext(input logic [SIZE_DATA-1:0] v);
    return {{(SIZE_ACC-SIZE_DATA){v[SIZE_DATA-1]}}, v};
  endfunction

  logic [SIZE_DELAY-1:0] k_q, l_q;
  logic [SIZE_M-1:0]     m_q;
  logic [4:0]            norm_q;
  logic                  cfg_err_q;
  logic                  v1_q, v2_q, v3_q, v4_q, out_valid_q;

  logic [SIZE_DELAY:0]   req_sum;
  logic                  cfg_ok, cfg_accept, cfg_reject, sample_take;
  logic [SIZE_DELAY:0]   act_sum_m1;
  logic [SIZE_DELAY-1:0] tap_k, tap_l, tap_kl;
  logic signed [SIZE_ACC-1:0] m_ext;

  assign req_sum     = {1'b0, cfg_k} + {1'b0, cfg_l};
  assign cfg_ok      = (cfg_k != '0) && (cfg_l != '0) &&
                       (req_sum <= (SIZE_DELAY+1)'(MAX_DELAY));
  assign cfg_accept  = cfg_load & cfg_ok;
  assign cfg_reject  = cfg_load & ~cfg_ok;
  // A sample arriving with an accepted reconfiguration is discarded.
  assign sample_take = in_valid & ~cfg_accept;

  // History index j-1 holds v(n-j); k+l never exceeds MAX_DELAY so it fits.
  assign act_sum_m1  = {1'b0, k_q} + {1'b0, l_q} - (SIZE_DELAY+1)'(1);
  assign tap_k       = k_q - SIZE_DELAY'(1);
  assign tap_l       = l_q - SIZE_DELAY'(1);
  assign tap_kl      = act_sum_m1[SIZE_DELAY-1:0];
  assign m_ext       = {{(SIZE_ACC-SIZE_M){1'b0}}, m_q};

  // Active configuration and one-cycle reject flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q       <= SIZE_DELAY'(DEFAULT_K);
      l_q       <= SIZE_DELAY'(DEFAULT_L);
      m_q       <= SIZE_M'(DEFAULT_M);
      norm_q    <= 5'(DEFAULT_NORM);
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_reject;
      if (cfg_accept) begin
        k_q    <= cfg_k;
        l_q    <= cfg_l;
        m_q    <= cfg_m;
        norm_q <= cfg_norm;
      end
    end
  end

  // Pipeline valid chain; an accepted reconfiguration kills everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      v4_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (cfg_accept) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      v4_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      v1_q        <= sample_take;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      v4_q        <= v3_q;
      out_valid_q <= v4_q;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;

  for (genvar c = 0; c < CHANNEL_SIZE; c++) begin : g_ch
    logic [SIZE_DATA-1:0]       x;
    logic [SIZE_DATA-1:0]       hist_q [MAX_DELAY];
    logic signed [SIZE_ACC-1:0] d_d, d1_q, p_q, d2_q, r3_q, s_q, s_sh;
    logic [SIZE_ACC-SIZE_OUT:0] s_top;
    logic                       ovf;
    logic [SIZE_OUT-1:0]        out_d, out_q;
    logic                       sat_q;

    assign x   = in_data[c*SIZE_DATA +: SIZE_DATA];
    assign d_d = sext(x) - sext(hist_q[tap_k]) - sext(hist_q[tap_l]) + sext(hist_q[tap_kl]);

    // Sample history, shifted once per accepted sample.
    always_ff @(posedge clk or posedge reset) begin
      if (reset || cfg_accept) begin
        for (int i = 0; i < MAX_DELAY; i++) hist_q[i] <= '0;
      end else if (sample_take) begin
        hist_q[0] <= x;
        for (int i = 1; i < MAX_DELAY; i++) hist_q[i] <= hist_q[i-1];
      end
    end

    // Difference, first integrator, pole-zero sum and second integrator.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        d1_q <= '0;
        p_q  <= '0;
        d2_q <= '0;
        r3_q <= '0;
        s_q  <= '0;
      end else if (cfg_accept) begin
        d1_q <= '0;
        p_q  <= '0;
        d2_q <= '0;
        r3_q <= '0;
        s_q  <= '0;
      end else begin
        if (sample_take) d1_q <= d_d;
        if (v1_q) begin
          p_q  <= p_q + d1_q;
          d2_q <= d1_q;
        end
        if (v2_q) r3_q <= p_q + m_ext * d2_q;
        if (v3_q) s_q  <= s_q + r3_q;
      end
    end

    // Normalise, then clip when the shifted value does not fit the output.
    assign s_sh  = s_q >>> norm_q;
    assign s_top = s_sh[SIZE_ACC-1:SIZE_OUT-1];
    assign ovf   = !((&s_top) || !(|s_top));
    always_comb begin
      out_d = s_sh[SIZE_OUT-1:0];
      if (ovf) out_d = s_sh[SIZE_ACC-1] ? {1'b1, {(SIZE_OUT-1){1'b0}}}
                                        : {1'b0, {(SIZE_OUT-1){1'b1}}};
    end

    // Output register, loaded once per beat leaving the integrator.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_q <= '0;
        sat_q <= 1'b0;
      end else if (cfg_accept) begin
        sat_q <= 1'b0;
      end else if (v4_q) begin
        out_q <= out_d;
        sat_q <= ovf;
      end
    end

    assign out_data[c*SIZE_OUT +: SIZE_OUT] = out_q;
    assign out_sat[c] = sat_q;
  end

endmodule

// File: tb/tb_trapez_shaper_multi.sv
// Bench for trapez_shaper_multi: two instances (default widths and a
// 17-bit output variant), directed stimulus, a reference model that pushes
// expected beats into per-instance queues, and monitors that pop them.
module tb_trapez_shaper_multi;

  logic        clk, reset;
  logic        cfg_load0, cfg_load1;
  logic [8:0]  cfg_k0, cfg_l0, cfg_k1, cfg_l1;
  logic [7:0]  cfg_m0, cfg_m1;
  logic [4:0]  cfg_norm0, cfg_norm1;
  logic        cfg_err0, cfg_err1;
  logic        in_valid0, in_valid1;
  logic [31:0] in_data0, in_data1;
  logic        out_valid0, out_valid1;
  logic [49:0] out_data0;
  logic [33:0] out_data1;
  logic [1:0]  out_sat0, out_sat1;

  int     errors = 0;
  int     checks = 0;
  longint ecnt   = 0;

  typedef struct {
    longint    e0;
    longint    e1;
    logic [1:0] sat;
    longint    edg;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  longint mh [2][2][301];
  longint mp [2][2];
  longint ms [2][2];
  int     mk [2], ml [2], mm [2], mn [2];

  trapez_shaper_multi dut0 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load0), .cfg_k(cfg_k0), .cfg_l(cfg_l0),
    .cfg_m(cfg_m0), .cfg_norm(cfg_norm0), .cfg_err(cfg_err0), .in_valid(in_valid0),
    .in_data(in_data0), .out_valid(out_valid0), .out_data(out_data0), .out_sat(out_sat0)
  );

  trapez_shaper_multi #(.SIZE_ADD_CAPACITY(1)) dut1 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load1), .cfg_k(cfg_k1), .cfg_l(cfg_l1),
    .cfg_m(cfg_m1), .cfg_norm(cfg_norm1), .cfg_err(cfg_err1), .in_valid(in_valid1),
    .in_data(in_data1), .out_valid(out_valid1), .out_data(out_data1), .out_sat(out_sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction
  function automatic exp_t qfront(input int u);
    return (u == 0) ? q0[0] : q1[0];
  endfunction
  function automatic void qpop(input int u);
    if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction
  function automatic void qpush(input int u, input exp_t e);
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endfunction
  function automatic void qflush(input int u);
    if (u == 0) q0.delete(); else q1.delete();
  endfunction

  function automatic void mclear(input int u);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 301; i++) mh[u][c][i] = 0;
      mp[u][c] = 0;
      ms[u][c] = 0;
    end
  endfunction

  function automatic void mdefaults();
    for (int u = 0; u < 2; u++) begin
      mk[u] = 25; ml[u] = 20; mm[u] = 0; mn[u] = 10;
      mclear(u);
      qflush(u);
    end
  endfunction

  // Direct-form model of one sample beat; expected result lands 4 edges later.
  function automatic void mpush(input int u, input longint x0, input longint x1, input longint edg);
    exp_t   e;
    longint d, r, y, lim;
    int     so;
    so    = (u == 0) ? 25 : 17;
    lim   = longint'(1) <<< (so - 1);
    e.edg = edg;
    e.sat = 2'b00;
    e.e0  = 0;
    e.e1  = 0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 300; i > 0; i--) mh[u][c][i] = mh[u][c][i-1];
      mh[u][c][0] = (c == 0) ? x0 : x1;
      d = mh[u][c][0] - mh[u][c][mk[u]] - mh[u][c][ml[u]] + mh[u][c][mk[u] + ml[u]];
      mp[u][c] += d;
      r = mp[u][c] + longint'(mm[u]) * d;
      ms[u][c] += r;
      y = ms[u][c] >>> mn[u];
      if (y > lim - 1) begin
        y = lim - 1; e.sat[c] = 1'b1;
      end else if (y < -lim) begin
        y = -lim; e.sat[c] = 1'b1;
      end
      if (c == 0) e.e0 = y; else e.e1 = y;
    end
    qpush(u, e);
  endfunction

  task automatic mon(input int u, input logic ov, input longint o0, input longint o1, input logic [1:0] sat);
    exp_t e;
    if (qsize(u) > 0 && qfront(u).edg == ecnt) begin
      e = qfront(u);
      qpop(u);
      chk($sformatf("out_valid%0d@%0d", u, ecnt), longint'(ov), 1);
      chk($sformatf("ch0_dut%0d@%0d", u, ecnt), o0, e.e0);
      chk($sformatf("ch1_dut%0d@%0d", u, ecnt), o1, e.e1);
      chk($sformatf("sat_dut%0d@%0d", u, ecnt), longint'(sat), longint'(e.sat));
    end else if (ov) begin
      chk($sformatf("spurious_valid%0d@%0d", u, ecnt), longint'(ov), 0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, out_valid0, $signed(out_data0[24:0]), $signed(out_data0[49:25]), out_sat0);
    mon(1, out_valid1, $signed(out_data1[16:0]), $signed(out_data1[33:17]), out_sat1);
  end

  // One cycle of stimulus on instance u, mirrored into the model.
  task automatic beat(input int u, input bit ld, input int k, input int l, input int m,
                      input int n, input bit v, input longint x0, input longint x1);
    bit acc;
    @(negedge clk);
    acc = ld && (k >= 1) && (l >= 1) && (k + l <= 300);
    if (u == 0) begin
      cfg_load0 = ld; cfg_k0 = k[8:0]; cfg_l0 = l[8:0]; cfg_m0 = m[7:0]; cfg_norm0 = n[4:0];
      in_valid0 = v;  in_data0 = {x1[15:0], x0[15:0]};
    end else begin
      cfg_load1 = ld; cfg_k1 = k[8:0]; cfg_l1 = l[8:0]; cfg_m1 = m[7:0]; cfg_norm1 = n[4:0];
      in_valid1 = v;  in_data1 = {x1[15:0], x0[15:0]};
    end
    if (acc) begin
      mk[u] = k; ml[u] = l; mm[u] = m; mn[u] = n;
      mclear(u);
      qflush(u);
    end else if (v) begin
      mpush(u, x0, x1, ecnt + 5);
    end
  endtask

  task automatic smp(input int u, input bit v, input longint x0, input longint x1);
    beat(u, 1'b0, 0, 0, 0, 0, v, x0, x1);
  endtask

  task automatic cfgl(input int u, input int k, input int l, input int m, input int n);
    beat(u, 1'b1, k, l, m, n, 1'b0, 0, 0);
  endtask

  task automatic step_seq(input int u, input int nz, input int n1, input longint a0,
                          input longint a1, input bit gap);
    for (int i = 0; i < nz + n1; i++) begin
      if (i < nz) smp(u, 1'b1, 0, 0);
      else        smp(u, 1'b1, a0, a1);
      if (gap) smp(u, 1'b0, 0, 0);
    end
    repeat (8) smp(u, 1'b0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_load0 = 0; cfg_k0 = 0; cfg_l0 = 0; cfg_m0 = 0; cfg_norm0 = 0; in_valid0 = 0; in_data0 = 0;
    cfg_load1 = 0; cfg_k1 = 0; cfg_l1 = 0; cfg_m1 = 0; cfg_norm1 = 0; in_valid1 = 0; in_data1 = 0;
    reset = 1'b1;
    mdefaults();
    #2;
    chk("rst_out_valid0", longint'(out_valid0), 0);
    chk("rst_out_data0",  longint'(out_data0), 0);
    chk("rst_out_sat0",   longint'(out_sat0), 0);
    chk("rst_cfg_err0",   longint'(cfg_err0), 0);
    chk("rst_out_valid1", longint'(out_valid1), 0);
    chk("rst_out_data1",  longint'(out_data1), 0);
    @(negedge clk);
    reset = 1'b0;

    // Step response, k=4 l=6
    cfgl(0, 4, 6, 0, 0);
    smp(0, 1'b1, 0, 0);
    chk("cfg_err_after_accept", longint'(cfg_err0), 0);
    step_seq(0, 2, 14, 100, 0, 1'b0);

    // Same step with in_valid every other cycle
    cfgl(0, 4, 6, 0, 0);
    step_seq(0, 2, 14, 100, 0, 1'b1);

    // Normalisation with a negative step
    cfgl(0, 4, 6, 0, 2);
    step_seq(0, 2, 14, -100, 0, 1'b0);

    // Rejected load during a step; sample in that cycle still processed
    cfgl(0, 4, 6, 0, 0);
    repeat (3) smp(0, 1'b1, 100, 0);
    beat(0, 1'b1, 200, 150, 0, 0, 1'b1, 100, 0);
    smp(0, 1'b1, 100, 0);
    chk("cfg_err_pulse", longint'(cfg_err0), 1);
    smp(0, 1'b1, 100, 0);
    chk("cfg_err_clear", longint'(cfg_err0), 0);
    step_seq(0, 0, 10, 100, 0, 1'b0);

    // Pole-zero term, swapped k/l, both channels active
    cfgl(0, 6, 4, 3, 1);
    step_seq(0, 2, 14, 100, -60, 1'b0);

    // Accepted reconfiguration at the third step sample
    cfgl(0, 4, 6, 0, 0);
    repeat (2) smp(0, 1'b1, 100, 0);
    beat(0, 1'b1, 4, 6, 0, 0, 1'b1, 100, 0);
    smp(0, 1'b1, 100, 0);
    chk("valid_after_reconfig", longint'(out_valid0), 0);
    step_seq(0, 0, 11, 100, 0, 1'b0);

    // Saturation on the 17-bit output instance
    cfgl(1, 4, 4, 0, 0);
    step_seq(1, 1, 12, 32767, 0, 1'b0);

    // Asynchronous reset in the middle of a pulse
    cfgl(0, 4, 6, 0, 0);
    repeat (6) smp(0, 1'b1, 100, 0);
    chk("pre_reset_valid", longint'(out_valid0), 1);
    #2;
    in_valid0 = 1'b0;
    reset = 1'b1;
    mdefaults();
    #1;
    chk("async_rst_out_valid0", longint'(out_valid0), 0);
    chk("async_rst_out_data0",  longint'(out_data0), 0);
    chk("async_rst_out_sat0",   longint'(out_sat0), 0);
    chk("async_rst_out_valid1", longint'(out_valid1), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Default configuration after reset (k=25 l=20 m=0 norm=10)
    step_seq(0, 0, 50, 1000, -500, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
